// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between the baud generator and a serial TX/RX engine.
// The engine (master) drives rate/enable controls; the generator (slave) returns ticks.
interface baud_tick_gen_if #(
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = 10
);
    logic                          en;
    logic [2:0]                    baud_sel;
    logic                          div_load;
    logic [CNT_W-1:0]              div_val;
    logic                          tick_os;
    logic                          tick_mid;
    logic                          tick_end;
    logic                          frame_done;
    logic [$clog2(FRAME_BITS)-1:0] bit_idx;
    logic                          div_err;

    modport master (
        output en, baud_sel, div_load, div_val,
        input  tick_os, tick_mid, tick_end, frame_done, bit_idx, div_err
    );

    modport slave (
        input  en, baud_sel, div_load, div_val,
        output tick_os, tick_mid, tick_end, frame_done, bit_idx, div_err
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Run-time selectable UART bit-clock generator: oversample, mid-bit and end-of-bit
// ticks plus a bit/frame counter, with a loadable custom divisor.
module baud_tick_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 16,
    parameter int FRAME_BITS = 10
) (
    input logic            clk,
    input logic            rst,
    baud_tick_gen_if.slave bus
);
    localparam int BW    = $clog2(FRAME_BITS);
    localparam int OS_SH = $clog2(OVERSAMPLE);

    localparam logic [CNT_W:0]   ONE_W   = 1;
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2*OVERSAMPLE-1);
    localparam logic [BW-1:0]    LAST_BIT = BW'(FRAME_BITS-1);

    function automatic logic [CNT_W-1:0] tbl_div(input int baud);
        return CNT_W'((CLK_HZ + baud/2)/baud - 1);
    endfunction

    // Oversample period-1 from a bit period-1: floor((d+1)/OVERSAMPLE) - 1.
    function automatic logic [CNT_W-1:0] os_of(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] p;
        p = {1'b0, d} + ONE_W;
        p = (p >> OS_SH) - ONE_W;
        return p[CNT_W-1:0];
    endfunction

    localparam logic [CNT_W-1:0] D_9600   = tbl_div(9600);
    localparam logic [CNT_W-1:0] D_19200  = tbl_div(19200);
    localparam logic [CNT_W-1:0] D_38400  = tbl_div(38400);
    localparam logic [CNT_W-1:0] D_57600  = tbl_div(57600);
    localparam logic [CNT_W-1:0] D_115200 = tbl_div(115200);
    localparam logic [CNT_W-1:0] OS_9600  = os_of(D_9600);

    logic                r_en_q;
    logic [CNT_W-1:0]    r_div;
    logic [CNT_W-1:0]    r_os_div;
    logic [CNT_W-1:0]    r_cust;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_os_cnt;
    logic [BW-1:0]       r_bit;
    logic                r_tick_os;
    logic                r_tick_mid;
    logic                r_tick_end;
    logic                r_frame_done;
    logic                r_div_err;

    logic                w_rise;
    logic [CNT_W-1:0]    w_src;
    logic [CNT_W-1:0]    w_div;
    logic [CNT_W-1:0]    w_os_div;
    logic                w_cnt_wrap;
    logic                w_os_wrap;
    logic                w_mid_hit;
    logic                w_last_bit;
    logic                w_load_ok;

    assign w_rise = bus.en & ~r_en_q;

    always_comb begin
        w_src = r_cust;
        case (bus.baud_sel)
            3'd0:    w_src = D_9600;
            3'd1:    w_src = D_19200;
            3'd2:    w_src = D_38400;
            3'd3:    w_src = D_57600;
            3'd4:    w_src = D_115200;
            default: w_src = r_cust;
        endcase
    end

    // On the latch edge the compares already see the freshly selected divisor.
    assign w_div      = w_rise ? w_src        : r_div;
    assign w_os_div   = w_rise ? os_of(w_src) : r_os_div;
    assign w_cnt_wrap = (r_cnt == w_div);
    assign w_os_wrap  = (r_os_cnt == w_os_div);
    assign w_mid_hit  = (r_cnt == (w_div >> 1));
    assign w_last_bit = (r_bit == LAST_BIT);
    assign w_load_ok  = ~bus.en & (bus.div_val >= DIV_MIN);

    // Divisor selection and custom register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_q    <= 1'b0;
            r_div     <= D_9600;
            r_os_div  <= OS_9600;
            r_cust    <= D_9600;
            r_div_err <= 1'b0;
        end else begin
            r_en_q    <= bus.en;
            r_div_err <= bus.div_load & ~w_load_ok;
            if (bus.div_load && w_load_ok)
                r_cust <= bus.div_val;
            if (w_rise) begin
                r_div    <= w_src;
                r_os_div <= os_of(w_src);
            end
        end
    end

    // Counters and registered tick pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_os_cnt     <= '0;
            r_bit        <= '0;
            r_tick_os    <= 1'b0;
            r_tick_mid   <= 1'b0;
            r_tick_end   <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!bus.en) begin
            r_cnt        <= '0;
            r_os_cnt     <= '0;
            r_bit        <= '0;
            r_tick_os    <= 1'b0;
            r_tick_mid   <= 1'b0;
            r_tick_end   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            r_os_cnt     <= (w_cnt_wrap || w_os_wrap) ? '0 : r_os_cnt + 1'b1;
            if (w_cnt_wrap)
                r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
            r_tick_os    <= w_os_wrap;
            r_tick_mid   <= w_mid_hit;
            r_tick_end   <= w_cnt_wrap;
            r_frame_done <= w_cnt_wrap & w_last_bit;
        end
    end

    assign bus.tick_os    = r_tick_os;
    assign bus.tick_mid   = r_tick_mid;
    assign bus.tick_end   = r_tick_end;
    assign bus.frame_done = r_frame_done;
    assign bus.bit_idx    = r_bit;
    assign bus.div_err    = r_div_err;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed and random en/rate/load traffic against an
// arithmetic model of tick positions derived from the edge count since en rose.
module tb_baud_tick_gen;
    localparam int CLK_HZ = 50000000;
    localparam int OS     = 16;
    localparam int CNT_W  = 16;
    localparam int FB     = 10;
    localparam int BW     = $clog2(FB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    baud_tick_gen_if #(.CNT_W(CNT_W), .FRAME_BITS(FB)) bus();

    baud_tick_gen #(
        .CLK_HZ(CLK_HZ), .OVERSAMPLE(OS), .CNT_W(CNT_W), .FRAME_BITS(FB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: latched divisor, custom register, edges since en rose.
    int tbl[5];
    int m_div, m_cust, m_k;
    bit m_prev;
    logic [8:0] exp_v;
    int first_mid, first_end, first_fd, n_end, n_os, n_mid;

    function automatic logic [8:0] obs();
        return {bus.tick_os, bus.tick_mid, bus.tick_end, bus.frame_done, bus.bit_idx, bus.div_err};
    endfunction

    task automatic m_reset();
        m_div  = tbl[0];
        m_cust = tbl[0];
        m_k    = 0;
        m_prev = 1'b0;
    endtask

    task automatic seg_clr();
        first_mid = 0; first_end = 0; first_fd = 0;
        n_end = 0; n_os = 0; n_mid = 0;
    endtask

    task automatic model_edge(input bit en, input int sel, input bit ld, input int dv);
        bit e_err, e_os, e_mid, e_end, e_fd;
        int p, j, osd, e_bit;
        e_err = ld && (en || dv < 2*OS-1);
        if (en && !m_prev) begin
            m_div = (sel >= 5) ? m_cust : tbl[sel];
            m_k   = 0;
        end
        if (ld && !e_err) m_cust = dv;
        {e_os, e_mid, e_end, e_fd} = 4'b0;
        e_bit = 0;
        if (en) begin
            m_k++;
            p     = m_div + 1;
            osd   = p / OS - 1;
            j     = (m_k - 1) % p;
            e_os  = (j % (osd + 1)) == osd;
            e_mid = j == m_div / 2;
            e_end = (m_k % p) == 0;
            e_bit = (m_k / p) % FB;
            e_fd  = e_end && e_bit == 0;
        end else begin
            m_k = 0;
        end
        m_prev = en;
        exp_v = {e_os, e_mid, e_end, e_fd, BW'(e_bit), e_err};
    endtask

    // One clock: drive, model the edge, compare 1 time unit later.
    task automatic cyc(input bit en, input int sel, input bit ld, input int dv);
        bus.en       = en;
        bus.baud_sel = 3'(sel);
        bus.div_load = ld;
        bus.div_val  = CNT_W'(dv);
        @(posedge clk);
        model_edge(en, sel, ld, dv);
        #1;
        chk("outs", 32'(obs()), 32'(exp_v));
        if (bus.tick_mid && first_mid == 0) first_mid = m_k;
        if (bus.tick_end && first_end == 0) first_end = m_k;
        if (bus.frame_done && first_fd == 0) first_fd = m_k;
        n_end += int'(bus.tick_end);
        n_os  += int'(bus.tick_os);
        n_mid += int'(bus.tick_mid);
    endtask

    initial begin
        int bauds[5] = '{9600, 19200, 38400, 57600, 115200};
        for (int i = 0; i < 5; i++) tbl[i] = (CLK_HZ + bauds[i]/2) / bauds[i] - 1;
        m_reset();
        seg_clr();
        bus.en = 1'b0; bus.baud_sel = 3'd0; bus.div_load = 1'b0; bus.div_val = '0;

        #1 chk("reset_outs", 32'(obs()), 32'd0);
        chk("tbl0", 32'(tbl[0]), 32'd5207);
        chk("tbl4", 32'(tbl[4]), 32'd433);
        #20;
        @(negedge clk) rst = 1'b0;

        // 9600 from reset, two bits
        repeat (10464) cyc(1, 0, 0, 0);
        chk("t1_first_mid", 32'(first_mid), 32'd2604);
        chk("t1_first_end", 32'(first_end), 32'd5208);
        chk("t1_n_end", 32'(n_end), 32'd2);
        repeat (3) cyc(0, 0, 0, 0);

        // 115200 for one bit
        seg_clr();
        repeat (434) cyc(1, 4, 0, 0);
        chk("t2_n_os", 32'(n_os), 32'd16);
        chk("t2_first_end", 32'(first_end), 32'd434);
        repeat (2) cyc(0, 4, 0, 0);

        // 57600 full frame
        seg_clr();
        repeat (8690) cyc(1, 3, 0, 0);
        chk("t3_frame_done", 32'(first_fd), 32'd8680);
        chk("t3_n_end", 32'(n_end), 32'd10);
        repeat (2) cyc(0, 3, 0, 0);

        // custom divisor 99, then rejected loads
        cyc(0, 5, 1, 99);
        cyc(0, 5, 0, 0);
        seg_clr();
        repeat (100) cyc(1, 5, 0, 0);
        chk("t4_first_mid", 32'(first_mid), 32'd50);
        chk("t4_first_end", 32'(first_end), 32'd100);
        chk("t4_n_os", 32'(n_os), 32'd16);
        repeat (150) cyc(1, 5, 0, 0);
        cyc(0, 5, 0, 0);
        cyc(0, 5, 1, 20);
        cyc(0, 5, 0, 0);
        cyc(1, 5, 1, 77);
        repeat (2) cyc(0, 5, 0, 0);
        seg_clr();
        repeat (120) cyc(1, 5, 0, 0);
        chk("t4_keep_end", 32'(first_end), 32'd100);
        repeat (2) cyc(0, 5, 0, 0);

        // baud_sel change mid-transfer is ignored until en re-rises
        seg_clr();
        repeat (5208) cyc(1, 0, 0, 0);
        repeat (800) cyc(1, 4, 0, 0);
        chk("t5_n_end", 32'(n_end), 32'd1);
        repeat (2) cyc(0, 4, 0, 0);
        seg_clr();
        repeat (434) cyc(1, 4, 0, 0);
        chk("t5_new_end", 32'(first_end), 32'd434);
        repeat (2) cyc(0, 4, 0, 0);

        // en dropped at cnt=3000
        repeat (3000) cyc(1, 0, 0, 0);
        seg_clr();
        repeat (20) cyc(0, 0, 0, 0);
        chk("t6_quiet", 32'(n_end + n_os + n_mid), 32'd0);

        // random segments with random custom loads
        for (int s = 0; s < 14; s++) begin
            int sel, len;
            sel = int'($urandom_range(1, 7));
            cyc(0, sel, 1, int'($urandom_range(0, 400)));
            len = int'($urandom_range(50, 1400));
            for (int c = 0; c < len; c++)
                cyc(1, int'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0),
                    int'($urandom_range(0, 400)));
            repeat (int'($urandom_range(1, 4))) cyc(0, sel, 0, 0);
        end

        // reset mid-frame drops the custom divisor
        cyc(0, 5, 1, 99);
        repeat (700) cyc(1, 5, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'(obs()), 32'd0);
        m_reset();
        @(posedge clk);
        #1 chk("rst_hold", 32'(obs()), 32'd0);
        #2 rst = 1'b0;
        seg_clr();
        repeat (5300) cyc(1, 5, 0, 0);
        chk("t8_first_end", 32'(first_end), 32'd5208);
        chk("t8_first_mid", 32'(first_mid), 32'd2604);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor of the single-rate UART bit-clock divider.
- Generates three tick streams while a transfer is active:
  - an oversample tick;
  - a mid-bit sample tick;
  - an end-of-bit tick.
- Baud rate is selected at run time from a fixed table or a loadable custom divisor.
- Counts bits within a frame and flags frame completion.
- Sits between the system clock and UART/PS2-style serial TX/RX engines.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- OVERSAMPLE, 16, oversample ticks per bit period. Power of two, 4..32.
- CNT_W, 16, width of the divisor and bit counter.
- FRAME_BITS, 10, bits per frame (start + data + stop).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  transfer active. Low holds all counters at 0.
- baud_sel  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5..7=custom divisor.
- div_load  in  1  one-cycle strobe that loads div_val into the custom divisor.
- div_val  in  CNT_W  custom divisor value (period-1).
- tick_os  out  1  oversample pulse.
- tick_mid  out  1  mid-bit pulse.
- tick_end  out  1  end-of-bit pulse.
- frame_done  out  1  pulse on the end of the last bit of a frame.
- bit_idx  out  $clog2(FRAME_BITS)  index of the current bit.
- div_err  out  1  pulse when a custom load is rejected.

Behaviour:
- Reset (async, rst=1):
  - cnt, os_cnt, bit_idx = 0; all tick outputs and div_err = 0.
  - div_r = table entry 0; custom register = table entry 0.
- Table entries are elaboration-time constants: D(b) = (CLK_HZ + b/2)/b - 1, integer arithmetic. At 50 MHz: 5207, 2603, 1301, 867, 433.
- os_div = (div_r+1)/OVERSAMPLE - 1, floor, computed at latch time.
- Divisor latch:
  - div_r and os_div are latched only on the edge where en is sampled high and en was low on the previous edge.
  - Source is the table entry, or the custom register when baud_sel >= 5.
  - baud_sel changes while en=1 are ignored until the next en rising edge.
- Custom load:
  - div_load with en=0 and div_val >= 2*OVERSAMPLE-1 updates the custom register.
  - Otherwise the register is unchanged and div_err pulses high for exactly 1 cycle on the following edge.
- Main counter:
  - en=0: cnt is held at 0 on every edge.
  - en=1: if cnt==div_r, cnt wraps to 0; else cnt increments by 1.
  - Bit period = div_r+1 cycles.
  - Edge numbering: edge 1 is the first edge with en sampled high. Comparisons use the div_r value already latched (cnt=0 on edge 1 cannot match).
- Oversample counter:
  - os_cnt wraps when os_cnt==os_div.
  - os_cnt is forced to 0 on any edge where cnt wraps.
  - Result: exactly OVERSAMPLE tick_os per bit, re-aligned every bit.
- Ticks are registered, 1-cycle pulses, asserted on the edge after the compare is true, and only while en=1:
  - tick_mid when cnt == div_r>>1.
  - tick_end when cnt == div_r.
  - tick_os when os_cnt == os_div.
  - Coincident os_cnt wrap and cnt wrap produce one tick_os, not two.
- Bit counter:
  - bit_idx increments on each cnt wrap.
  - At the wrap with bit_idx == FRAME_BITS-1, bit_idx returns to 0 and frame_done pulses in the same cycle as that tick_end.
  - Frames repeat continuously while en=1.
- en deasserted mid-bit:
  - Next edge clears cnt, os_cnt, bit_idx.
  - No tick is emitted on or after that edge. A tick already registered from the previous compare still completes its single cycle.
- rst asserted at any time: outputs clear immediately (asynchronously); the custom divisor is lost.

Test Plan:
- Reset, baud_sel=0, raise en and hold:
  - tick_mid first high after edge 2604; tick_end after edge 5208, then every 5208 cycles.
  - tick_mid every 5208 cycles, offset 2604.
- baud_sel=4, en=1 for one bit:
  - tick_end period 434 cycles.
  - Exactly 16 tick_os per bit, spaced 27 cycles, 2-cycle gap before the re-align.
- FRAME_BITS=10, baud_sel=3:
  - bit_idx steps 0..9.
  - frame_done coincides with the 10th tick_end (edge 8680), then bit_idx=0.
- Custom divisor:
  - en=0, div_load with div_val=99 → later en=1 with baud_sel=5 gives period 100, tick_mid after edge 50, os_div=5.
  - div_load with div_val=20 → div_err 1-cycle pulse; divisor unchanged.
  - div_load with en=1 → div_err pulse; divisor unchanged.
- Change baud_sel 0→4 mid-transfer:
  - Period stays 5208 until en drops and re-rises, then becomes 434.
- Mode-change and reset disturbances:
  - Drop en at cnt=3000: no further ticks; cnt=0 next edge.
  - Assert rst mid-frame: all outputs 0 asynchronously; after release, the default 5207 divisor is in use.
